// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver with event FIFO.
// Build option PS2_BREAK_REPORT_EN is consumed by ps2_rx_fifo.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        CHECK
    } ps2_state_t;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam int unsigned StatOvfBit  = 15;
    localparam int unsigned StatFerrBit = 14;
    localparam int unsigned StatCntMsb  = 8;
    localparam int unsigned StatCntLsb  = 1;
    localparam int unsigned StatNeBit   = 0;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(logic [7:0] data, logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of key events; a simultaneous push and pop both commit,
// and the popped head is read before the write lands.
module ps2_evt_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  ps2_evt_t                 wdata_i,
    input  logic                     pop_i,
    output ps2_evt_t                 rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

    ps2_evt_t         mem_q [Depth];
    logic [AddrW-1:0] wptr_q, wptr_d;
    logic [AddrW-1:0] rptr_q, rptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // When full, a push is only accepted if the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: filtered clock, checked 11-bit frames, E0/F0 prefix
// decoding and a key-event FIFO behind one I/O slot. Option: PS2_BREAK_REPORT_EN.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2c,
    input  logic        ps2d,
    input  logic        ack,
    output logic [15:0] dout
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);

    logic [1:0]            c_sync_q, d_sync_q;
    logic [FILTER_LEN-1:0] filt_q, filt_d;
    logic                  level_q, level_d;
    logic                  fall_q, fall_d;
    logic                  din;

    ps2_state_t            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  stop_q, stop_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  frame_ok, frame_bad;

    logic                  ext_pend_q, ext_pend_d;
    logic                  brk_pend_q, brk_pend_d;
    logic                  push;
    ps2_evt_t              evt_in, fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [CntW-1:0]       fifo_cnt;

    logic                  ack_q, ack_prev_q, pop_req;
    logic                  ovf_q, ovf_d;
    logic                  ferr_q, ferr_d;

    assign din = d_sync_q[1];

    // Line filter: level only moves once the whole window agrees.
    assign filt_d = {filt_q[FILTER_LEN-2:0], c_sync_q[1]};

    always_comb begin
        level_d = level_q;
        if (&filt_d) begin
            level_d = 1'b1;
        end else if (~|filt_d) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        tmo_d     = fall_q ? '0 : ((tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1);
        unique case (state_q)
            IDLE: begin
                if (fall_q && !din) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (fall_q) begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_q) begin
                    par_d   = din;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    stop_d  = din;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (stop_q && odd_parity_ok(shift_q, par_q)) begin
                    frame_ok = 1'b1;
                end else begin
                    frame_bad = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if ((state_q inside {DATA, PARITY, STOP}) && !fall_q && tmo_q == TmoMax) begin
            state_d   = IDLE;
            frame_bad = 1'b1;
        end
    end

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        push        = 1'b0;
        evt_in.ext  = ext_pend_q;
        evt_in.brk  = brk_pend_q;
        evt_in.code = shift_q;
        if (frame_ok) begin
            if (shift_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (shift_q == PS2_BREAK) begin
                brk_pend_d = 1'b1;
            end else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
`ifdef PS2_BREAK_REPORT_EN
                push       = 1'b1;
`else
                push       = ~brk_pend_q;
`endif
            end
        end
    end

    assign pop_req = ack_prev_q & ~ack_q;

    // A newly raised error wins over a clear landing in the same cycle.
    always_comb begin
        ovf_d  = ovf_q;
        ferr_d = ferr_q;
        if (pop_req) begin
            ovf_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (push && fifo_full && !pop_req) begin
            ovf_d = 1'b1;
        end
        if (frame_bad) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q   <= '1;
            d_sync_q   <= '1;
            filt_q     <= '1;
            level_q    <= 1'b1;
            fall_q     <= 1'b0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            stop_q     <= 1'b0;
            tmo_q      <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            ack_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            c_sync_q   <= {c_sync_q[0], ps2c};
            d_sync_q   <= {d_sync_q[0], ps2d};
            filt_q     <= filt_d;
            level_q    <= level_d;
            fall_q     <= fall_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            stop_q     <= stop_d;
            tmo_q      <= tmo_d;
            ext_pend_q <= ext_pend_d;
            brk_pend_q <= brk_pend_d;
            ack_q      <= ack;
            ack_prev_q <= ack_q;
            ovf_q      <= ovf_d;
            ferr_q     <= ferr_d;
        end
    end

    ps2_evt_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .wdata_i (evt_in),
        .pop_i   (pop_req),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_comb begin
        dout = '0;
        if (ack) begin
            if (!fifo_empty) begin
                dout[9:0] = fifo_head;
            end
        end else begin
            dout[StatOvfBit]             = ovf_q;
            dout[StatFerrBit]            = ferr_q;
            dout[StatCntMsb:StatCntLsb]  = 8'(fifo_cnt);
            dout[StatNeBit]              = ~fifo_empty;
        end
    end

endmodule
